// File: rtl/mem_pkg.sv
// Shared types and geometry helpers for the banked instruction/data memory.
package mem_pkg;

  // Widest address/data the request struct can carry; ports zero-extend into it.
  localparam int REQ_AW = 32;
  localparam int REQ_DW = 64;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
  } port_req_t;

  function automatic int off_width(input int banksize);
    return $clog2(banksize);
  endfunction

  function automatic int bank_width(input int aw, input int banksize);
    return aw - $clog2(banksize);
  endfunction

  function automatic longint unsigned mem_limit(input int nbanks, input int banksize);
    return longint'(nbanks) * longint'(banksize);
  endfunction

endpackage

// File: rtl/mem_bank.sv
// Single-port synchronous RAM bank: write on the edge, registered read of the
// addressed word every cycle (the caller decides when the result is meaningful).
module mem_bank
  import mem_pkg::*;
#(
  parameter int DATAW    = 24,
  parameter int BANKSIZE = 4096
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [off_width(BANKSIZE)-1:0] addr,
  input  logic [DATAW-1:0]               wdata,
  output logic [DATAW-1:0]               rdata
);

  logic [DATAW-1:0] mem [BANKSIZE];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/banked_mem.sv
// Multi-bank memory with fetch and data ports, per-bank alternating arbitration,
// one-cycle read latency. BANKED_MEM_ERR_EN adds a registered out-of-range flag d_err.
module banked_mem
  import mem_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DATAW    = 24,
  parameter int BANKSIZE = 4096,
  parameter int NBANKS   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [AW-1:0]    i_addr,
  output logic             i_ready,
  output logic             i_rvalid,
  output logic [DATAW-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [DATAW-1:0] d_wdata,
  output logic             d_ready,
  output logic             d_rvalid,
  output logic [DATAW-1:0] d_rdata
`ifdef BANKED_MEM_ERR_EN
  ,
  output logic             d_err
`endif
);

  localparam int OFFW = off_width(BANKSIZE);
  localparam int BIW  = bank_width(AW, BANKSIZE);
  localparam logic [REQ_AW:0] LIMIT = (REQ_AW + 1)'(mem_limit(NBANKS, BANKSIZE));

  port_req_t i_pr, d_pr;

  always_comb begin
    i_pr       = '0;
    i_pr.req   = i_req;
    i_pr.addr  = REQ_AW'(i_addr);
    d_pr       = '0;
    d_pr.req   = d_req;
    d_pr.we    = d_we;
    d_pr.addr  = REQ_AW'(d_addr);
    d_pr.wdata = REQ_DW'(d_wdata);
  end

  logic unused_bits;
  assign unused_bits = ^{i_pr.we, i_pr.wdata, d_pr.wdata};

  logic [BIW-1:0]  i_bank, d_bank;
  logic [OFFW-1:0] i_off, d_off;
  logic            i_inr, d_inr;

  assign i_bank = i_pr.addr[AW-1:OFFW];
  assign d_bank = d_pr.addr[AW-1:OFFW];
  assign i_off  = i_pr.addr[OFFW-1:0];
  assign d_off  = d_pr.addr[OFFW-1:0];
  assign i_inr  = {1'b0, i_pr.addr} < LIMIT;
  assign d_inr  = {1'b0, d_pr.addr} < LIMIT;

  logic pri_i, conflict, i_acc, d_acc;

  // Out-of-range requests never touch a bank, so they can never collide.
  assign conflict = i_pr.req && d_pr.req && i_inr && d_inr && (i_bank == d_bank);
  assign i_ready  = !(conflict && !pri_i);
  assign d_ready  = !(conflict && pri_i);
  assign i_acc    = i_pr.req && i_ready;
  assign d_acc    = d_pr.req && d_ready;

  logic [DATAW-1:0] bank_rdata [NBANKS];

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic            sel_d;
    logic [OFFW-1:0] addr_b;

    assign sel_d  = d_acc && d_inr && (d_bank == BIW'(b));
    assign addr_b = sel_d ? d_off : i_off;

    mem_bank #(
      .DATAW   (DATAW),
      .BANKSIZE(BANKSIZE)
    ) u_bank (
      .clk  (clk),
      .we   (sel_d && d_pr.we),
      .addr (addr_b),
      .wdata(d_pr.wdata[DATAW-1:0]),
      .rdata(bank_rdata[b])
    );
  end

  logic             i_rv_q, d_rv_q, i_oor_q, d_oor_q;
  logic [BIW-1:0]   i_bank_q, d_bank_q;
  logic [DATAW-1:0] i_hold_q, d_hold_q, i_cur, d_cur;

  always_comb begin
    i_cur = '0;
    d_cur = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (i_bank_q == BIW'(b)) i_cur = bank_rdata[b];
      if (d_bank_q == BIW'(b)) d_cur = bank_rdata[b];
    end
    if (i_oor_q) i_cur = '0;
    if (d_oor_q) d_cur = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_i    <= 1'b0;
      i_rv_q   <= 1'b0;
      d_rv_q   <= 1'b0;
      i_oor_q  <= 1'b0;
      d_oor_q  <= 1'b0;
      i_bank_q <= '0;
      d_bank_q <= '0;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      if (conflict) pri_i <= !pri_i;
      i_rv_q <= i_acc;
      d_rv_q <= d_acc && !d_pr.we;
      if (i_acc) begin
        i_oor_q  <= !i_inr;
        i_bank_q <= i_bank;
      end
      if (d_acc && !d_pr.we) begin
        d_oor_q  <= !d_inr;
        d_bank_q <= d_bank;
      end
      // Capture the delivered word so rdata stays put between valid pulses.
      if (i_rv_q) i_hold_q <= i_cur;
      if (d_rv_q) d_hold_q <= d_cur;
    end
  end

  assign i_rvalid = i_rv_q;
  assign d_rvalid = d_rv_q;
  assign i_rdata  = i_rv_q ? i_cur : i_hold_q;
  assign d_rdata  = d_rv_q ? d_cur : d_hold_q;

`ifdef BANKED_MEM_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_err <= 1'b0;
    else        d_err <= d_acc && !d_inr;
  end
`endif

endmodule

// File: tb/tb_banked_mem.sv
// Scoreboard bench for banked_mem: default geometry plus a 4x1024 instance.
module tb_banked_mem;

  localparam int AW = 16;
  localparam int DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          i_req, i_ready, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ready, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;

  logic          b_i_req, b_i_ready, b_i_rvalid;
  logic [AW-1:0] b_i_addr;
  logic [DW-1:0] b_i_rdata;
  logic          b_d_req, b_d_we, b_d_ready, b_d_rvalid;
  logic [AW-1:0] b_d_addr;
  logic [DW-1:0] b_d_wdata, b_d_rdata;
`ifdef BANKED_MEM_ERR_EN
  logic d_err, b_d_err;
`endif

  banked_mem #(.AW(AW), .DATAW(DW), .BANKSIZE(4096), .NBANKS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata)
`ifdef BANKED_MEM_ERR_EN
    , .d_err(d_err)
`endif
  );

  banked_mem #(.AW(AW), .DATAW(DW), .BANKSIZE(1024), .NBANKS(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata)
`ifdef BANKED_MEM_ERR_EN
    , .d_err(b_d_err)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    int            at;
  } exp_t;

  exp_t exp_i[$], exp_d[$], exp_b[$];
  int checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int which, input logic [DW-1:0] data);
    exp_t e;
    e.data = data;
    e.at   = cyc + 1;
    if (which == 0) exp_i.push_back(e);
    else if (which == 1) exp_d.push_back(e);
    else exp_b.push_back(e);
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (i_rvalid) begin
      if (exp_i.size() == 0) begin
        checks++; errors++;
        $display("FAIL i_rvalid_unexpected: got rdata %0h, expected no response", i_rdata);
      end else begin
        e = exp_i.pop_front();
        check("i_rdata", i_rdata, e.data);
        check("i_rvalid_cycle", cyc, e.at);
      end
    end
    if (d_rvalid) begin
      if (exp_d.size() == 0) begin
        checks++; errors++;
        $display("FAIL d_rvalid_unexpected: got rdata %0h, expected no response", d_rdata);
      end else begin
        e = exp_d.pop_front();
        check("d_rdata", d_rdata, e.data);
        check("d_rvalid_cycle", cyc, e.at);
      end
    end
    if (b_d_rvalid) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_d_rvalid_unexpected: got rdata %0h, expected no response", b_d_rdata);
      end else begin
        e = exp_b.pop_front();
        check("b_d_rdata", b_d_rdata, e.data);
        check("b_d_rvalid_cycle", cyc, e.at);
      end
    end
  end

  task automatic d_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [DW-1:0] exp, input logic oor, output int acc);
    acc = -1;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (d_ready) begin
        acc = cyc;
        if (!we) push(1, exp);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
`ifdef BANKED_MEM_ERR_EN
        @(negedge clk);
        check("d_err", d_err, oor);
`endif
        return;
      end
    end
    d_req = 1'b0;
    checks++; errors++;
    $display("FAIL d_op_timeout: addr %0h never accepted, expected accept within 20 cycles (oor %0d)", a, oor);
  endtask

  task automatic i_op(input logic [AW-1:0] a, input logic [DW-1:0] exp, output int acc);
    acc = -1;
    i_req = 1'b1; i_addr = a;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (i_ready) begin
        acc = cyc;
        push(0, exp);
        @(posedge clk); #1;
        i_req = 1'b0;
        return;
      end
    end
    i_req = 1'b0;
    checks++; errors++;
    $display("FAIL i_op_timeout: addr %0h never accepted, expected accept within 20 cycles", a);
  endtask

  task automatic b_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [DW-1:0] exp, input logic oor);
    b_d_req = 1'b1; b_d_we = we; b_d_addr = a; b_d_wdata = wd;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b_d_ready) begin
        if (!we) push(2, exp);
        @(posedge clk); #1;
        b_d_req = 1'b0; b_d_we = 1'b0;
`ifdef BANKED_MEM_ERR_EN
        @(negedge clk);
        check("b_d_err", b_d_err, oor);
`endif
        return;
      end
    end
    b_d_req = 1'b0;
    checks++; errors++;
    $display("FAIL b_op_timeout: addr %0h never accepted, expected accept within 20 cycles (oor %0d)", a, oor);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_i, acc_d, start;
    rst_n = 1'b0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    b_i_req = 0; b_i_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;
    #12;
    check("rst_i_rvalid", i_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
`ifdef BANKED_MEM_ERR_EN
    check("rst_d_err", d_err, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back, data held afterwards.
    d_op(1, 16'h0005, 24'hABCDEF, 0, 0, acc_d);
    d_op(0, 16'h0005, 0, 24'hABCDEF, 0, acc_d);
    repeat (2) @(negedge clk);
    check("hold_d_rvalid", d_rvalid, 0);
    check("hold_d_rdata", d_rdata, 24'hABCDEF);
    @(posedge clk); #1;

    d_op(1, 16'h0000, 24'h666666, 0, 0, acc_d);
    d_op(1, 16'h0010, 24'h111111, 0, 0, acc_d);
    d_op(1, 16'h1010, 24'h222222, 0, 0, acc_d);
    d_op(1, 16'h0020, 24'h333333, 0, 0, acc_d);
    d_op(1, 16'h0030, 24'h444444, 0, 0, acc_d);
    @(posedge clk); #1;

    // Different banks in the same cycle: both accepted immediately.
    start = cyc;
    fork
      i_op(16'h0010, 24'h111111, acc_i);
      d_op(0, 16'h1010, 0, 24'h222222, 0, acc_d);
    join
    check("par_i_accept_cycle", acc_i, start);
    check("par_d_accept_cycle", acc_d, start);
    @(posedge clk); #1;

    // Sustained bank-0 conflict: data, fetch, data, fetch.
    i_req = 1; i_addr = 16'h0020; d_req = 1; d_we = 0; d_addr = 16'h0030;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cf_d_ready", d_ready, (k % 2 == 0));
      check("cf_i_ready", i_ready, (k % 2 == 1));
      if (d_ready) push(1, 24'h444444);
      if (i_ready) push(0, 24'h333333);
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    @(posedge clk); #1;

    // Out of range: write dropped (no alias into bank 0), reads return 0.
    d_op(1, 16'h3000, 24'h555555, 0, 1, acc_d);
    d_op(0, 16'h3000, 0, 24'h000000, 1, acc_d);
    d_op(0, 16'h0000, 0, 24'h666666, 0, acc_d);
    i_op(16'h3000, 24'h000000, acc_i);
    @(posedge clk); #1;

    // Four banks of 1024 words.
    b_op(1, 16'h0FFF, 24'h0A0B0C, 0, 0);
    b_op(1, 16'h0C00, 24'h0D0E0F, 0, 0);
    b_op(0, 16'h0FFF, 0, 24'h0A0B0C, 0);
    b_op(0, 16'h0C00, 0, 24'h0D0E0F, 0);
    b_op(1, 16'h1000, 24'h777777, 0, 1);
    b_op(0, 16'h1000, 0, 24'h000000, 1);
    @(posedge clk); #1;

    // Reset during an in-flight read after pri_i has been flipped.
    i_req = 1; i_addr = 16'h0020; d_req = 1; d_we = 0; d_addr = 16'h0030;
    @(negedge clk);
    check("pre_rst_d_ready", d_ready, 1);
    check("pre_rst_i_ready", i_ready, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_d_rvalid", d_rvalid, 0);
    check("mid_rst_d_rdata", d_rdata, 0);
    check("mid_rst_i_rvalid", i_rvalid, 0);
    check("mid_rst_i_rdata", i_rdata, 0);
`ifdef BANKED_MEM_ERR_EN
    check("mid_rst_d_err", d_err, 0);
`endif
    i_req = 0; d_req = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    i_req = 1; i_addr = 16'h0020; d_req = 1; d_we = 0; d_addr = 16'h0030;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("post_rst_d_ready", d_ready, (k == 0));
      check("post_rst_i_ready", i_ready, (k == 1));
      if (d_ready) push(1, 24'h444444);
      if (i_ready) push(0, 24'h333333);
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;

    repeat (3) @(negedge clk);
    check("drain_exp_i", exp_i.size(), 0);
    check("drain_exp_d", exp_d.size(), 0);
    check("drain_exp_b", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
